// File: rtl/slt_scan_unit_pkg.sv
// Shared ALU definitions used by the multi-cycle set-less-than path.
package slt_scan_unit_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // ALU opcodes that steer signed_mode upstream of this unit.
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

    // Resolve less-than from the first differing bit. In signed mode the
    // sign bit decides in the opposite sense: the operand holding a 1 there
    // is negative and therefore the smaller one.
    function automatic logic resolve_lt(input logic signed_mode,
                                        input logic is_msb,
                                        input logic a_bit,
                                        input logic b_bit);
        logic lt;
        if (signed_mode && is_msb) begin
            lt = a_bit;
        end else begin
            lt = b_bit;
        end
        return lt;
    endfunction

endpackage

// File: rtl/slt_scan_unit.sv
// Multi-cycle SLT/SLTU: latches operands and the equality vector, scans
// MSB to LSB one bit per cycle for the first mismatch, and reports lt.
module slt_scan_unit
    import slt_scan_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] eq_vec,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [WIDTH-1:0] Result
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   eq_q, eq_d;
    logic               signed_q, signed_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               equal_q, equal_d;
    logic               lt_q, lt_d;

    // Next-state, index counter and result resolution.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        eq_d     = eq_q;
        signed_d = signed_q;
        equal_d  = equal_q;
        lt_d     = lt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    eq_d     = eq_vec;
                    signed_d = signed_mode;
                    idx_d    = IDX_MAX;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
                if (!eq_q[idx_q]) begin
                    lt_d    = resolve_lt(signed_q, (idx_q == IDX_MAX),
                                         a_q[idx_q], b_q[idx_q]);
                    equal_d = 1'b0;
                    state_d = DONE;
                end else if (idx_q == {IDX_W{1'b0}}) begin
                    lt_d    = 1'b0;
                    equal_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                end
            end
            DONE: begin
                idx_d   = IDX_MAX;
                state_d = IDLE;
            end
            default: begin
                idx_d   = IDX_MAX;
                state_d = IDLE;
            end
        endcase

        // Status flags are derived from the next state so they are flopped
        // alongside it and line up with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, latched operands and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= IDX_MAX;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            eq_q     <= {WIDTH{1'b0}};
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            equal_q  <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            eq_q     <= eq_d;
            signed_q <= signed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            equal_q  <= equal_d;
            lt_q     <= lt_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign equal  = equal_q;
    assign Result = {{(WIDTH-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_slt_scan_unit.sv
// Self-checking bench for slt_scan_unit: table vectors, random operands
// against an arithmetic reference, and hand-written multi-cycle sequences.
module tb_slt_scan_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] eq_vec;
    logic        busy;
    logic        done;
    logic        equal;
    logic [31:0] Result;

    int n_checks;
    int n_fail;

    slt_scan_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .eq_vec      (eq_vec),
        .busy        (busy),
        .done        (done),
        .equal       (equal),
        .Result      (Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [31:0] res;
        logic        eqo;
        int          cyc;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: compare as numbers; latency from the highest differing bit.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sm, output logic lt,
                                  output logic eqo, output int cyc);
        if (sm) lt = ($signed(a) < $signed(b));
        else    lt = (a < b);
        eqo = (a == b);
        cyc = 33;
        for (int k = 0; k < 32; k++) begin
            if (a[k] != b[k]) cyc = 33 - k;
        end
    endfunction

    // Start one operation and watch it for 40 cycles (cycle c = after edge c).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic sm,
                          input int restart_cyc,
                          output int done_cyc, output int done_cnt,
                          output logic [31:0] res, output logic eqf,
                          output bit busy_ok, output bit idle_ok);
        @(negedge clk);
        A = a; B = b; eq_vec = eq; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        done_cyc = -1; done_cnt = 0; busy_ok = 1'b1; idle_ok = 1'b1;
        res = 32'h0; eqf = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == restart_cyc) begin
                start = 1'b1; A = 32'd9; B = 32'd0; eq_vec = ~(32'd9 ^ 32'd0);
            end else begin
                start = 1'b0; A = $urandom; B = $urandom; eq_vec = $urandom;
                signed_mode = 1'($urandom_range(0, 1));
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; res = Result; eqf = equal;
                end
            end
            if (done_cyc < 0 || done_cyc == c) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
            end else begin
                if (busy !== 1'b0) idle_ok = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    int          dc, dn;
    logic [31:0] r;
    logic        ef;
    bit          bok, iok;
    logic        m_lt, m_eq;
    int          m_cyc;
    logic [31:0] ra, rb;
    logic        rs;

    initial begin
        n_checks = 0; n_fail = 0;
        start = 1'b0; signed_mode = 1'b0; A = 32'h0; B = 32'h0; eq_vec = 32'h0;
        rst_n = 1'b0;

        tbl[0] = '{32'h00000005, 32'h00000007, 1'b0, 32'h1, 1'b0, 32};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h1, 1'b0, 2};
        tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 1'b0, 2};
        tbl[3] = '{32'h00001234, 32'h00001234, 1'b0, 32'h0, 1'b1, 33};
        tbl[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h1, 1'b0, 2};
        tbl[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 32'h1, 1'b0, 2};
        tbl[6] = '{32'h00000000, 32'h00000001, 1'b1, 32'h1, 1'b0, 33};
        tbl[7] = '{32'h00000003, 32'h00000002, 1'b0, 32'h0, 1'b0, 33};

        #12;
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_done",   32'(done),   32'h0);
        check("reset_equal",  32'(equal),  32'h0);
        check("reset_result", Result,      32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, ~(tbl[i].a ^ tbl[i].b), tbl[i].sm, -1,
                   dc, dn, r, ef, bok, iok);
            check($sformatf("tbl%0d_cycle", i),  32'(dc), 32'(tbl[i].cyc));
            check($sformatf("tbl%0d_result", i), r,       tbl[i].res);
            check($sformatf("tbl%0d_equal", i),  32'(ef), 32'(tbl[i].eqo));
            check($sformatf("tbl%0d_ndone", i),  32'(dn), 32'h1);
            check($sformatf("tbl%0d_busy", i),   32'(bok), 32'h1);
            check($sformatf("tbl%0d_idle", i),   32'(iok), 32'h1);
        end

        // Randomized operands, biased toward equal and single-bit differences.
        for (int t = 0; t < 60; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, m_lt, m_eq, m_cyc);
            run_op(ra, rb, ~(ra ^ rb), rs, -1, dc, dn, r, ef, bok, iok);
            check($sformatf("rnd%0d_cycle", t),  32'(dc), 32'(m_cyc));
            check($sformatf("rnd%0d_result", t), r,       32'(m_lt));
            check($sformatf("rnd%0d_equal", t),  32'(ef), 32'(m_eq));
            check($sformatf("rnd%0d_flow", t),   32'({bok, iok, dn == 1}), 32'h7);
        end

        // Start during SCAN is dropped.
        run_op(32'd1, 32'd2, ~(32'd1 ^ 32'd2), 1'b0, 10, dc, dn, r, ef, bok, iok);
        check("ignored_cycle",  32'(dc), 32'd32);
        check("ignored_ndone",  32'(dn), 32'd1);
        check("ignored_result", r,       32'h1);

        // Reset in the middle of a scan clears outputs asynchronously.
        @(negedge clk);
        A = 32'h0; B = 32'h80000000; eq_vec = ~(32'h0 ^ 32'h80000000);
        signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_pre_busy", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_done",   32'(done), 32'h0);
        check("rst_result", Result,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd3, 32'd2, ~(32'd3 ^ 32'd2), 1'b0, -1, dc, dn, r, ef, bok, iok);
        check("post_rst_cycle",  32'(dc), 32'd33);
        check("post_rst_result", r,       32'h0);
        check("post_rst_ndone",  32'(dn), 32'd1);

        // Back-to-back: start in the cycle right after done is accepted.
        @(negedge clk);
        A = 32'hFFFFFFFF; B = 32'h1; eq_vec = ~(32'hFFFFFFFF ^ 32'h1);
        signed_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("b2b_first_done",   32'(done), 32'h1);
        check("b2b_first_result", Result,    32'h1);
        @(negedge clk);
        check("b2b_gap_busy", 32'(busy), 32'h0);
        A = 32'h1; B = 32'hFFFFFFFF; eq_vec = ~(32'h1 ^ 32'hFFFFFFFF);
        signed_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", 32'(busy), 32'h1);
        check("b2b_hold_result", Result,    32'h1);
        @(negedge clk);
        check("b2b_second_done",   32'(done), 32'h1);
        check("b2b_second_result", Result,    32'h0);
        @(negedge clk);
        check("b2b_after_done", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
